// File: rtl/tow_engine.sv
// tow_engine: tug-of-war game core (button sync, random-delay round FSM, marker scoring, LED drive)
// Ports:
//   clk     in   1      game clock
//   rst     in   1      asynchronous, active-low reset
//   pbl     in   1      left push-button, raw
//   pbr     in   1      right push-button, raw
//   led     out  LED_W  registered track display (bit LED_W-1 = left end)
//   go      out  1      high while the round is armed
//   winner  out  2      {left,right} match winner, 2'b00 while playing
// Optional feature: define TOW_TIMEOUT_EN to void an armed round after 64 idle ticks.
module tow_engine #(
    parameter int          LED_W     = 7,
    parameter int          TICK_DIV  = 256,
    parameter int          WAIT_W    = 5,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pbl,
    input  logic             pbr,
    output logic [LED_W-1:0] led,
    output logic             go,
    output logic [1:0]       winner
);
    localparam int C  = (LED_W - 1) / 2;
    localparam int PW = $clog2(LED_W);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int CW = WAIT_W + 4;
    localparam logic [LED_W-1:0] LOW_M  = LED_W'((1 << C) - 1);
    localparam logic [LED_W-1:0] HIGH_M = LOW_M << (LED_W - C);

    typedef enum logic [1:0] {IDLE, WAIT, ARMED, WON} state_t;

    state_t          state, state_d;
    logic [2:0]      ls, rs;
    logic [TW-1:0]   tcnt;
    logic [7:0]      lfsr;
    logic [PW-1:0]   pos, pos_d;
    logic [CW-1:0]   wait_cnt, wait_d, reload;
    logic [1:0]      winner_d;
    logic [LED_W-1:0] led_d;
    logic            tick, pl, pr, single, left_pt, right_pt;
`ifdef TOW_TIMEOUT_EN
    logic [5:0]      to_cnt, to_d;
`endif

    assign tick   = tcnt == TW'(TICK_DIV - 1);
    assign pl     = ls[1] & ~ls[2];
    assign pr     = rs[1] & ~rs[2];
    assign single = pl ^ pr;
    assign reload = CW'(8) + CW'(lfsr[WAIT_W-1:0]);
    assign go     = state == ARMED;
    // A press while waiting is a false start and scores for the opponent.
    assign left_pt  = single & ((state == ARMED & pl) | (state == WAIT & pr));
    assign right_pt = single & ((state == ARMED & pr) | (state == WAIT & pl));

    // Sync flops reset high so a button held through reset never looks like a fresh press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ls   <= 3'b111;
            rs   <= 3'b111;
            tcnt <= '0;
            lfsr <= LFSR_SEED;
        end else begin
            ls   <= {ls[1:0], pbl};
            rs   <= {rs[1:0], pbr};
            tcnt <= tick ? '0 : tcnt + 1'b1;
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pos      <= PW'(C);
            wait_cnt <= '0;
            winner   <= 2'b00;
            led      <= LED_W'(1) << C;
`ifdef TOW_TIMEOUT_EN
            to_cnt   <= '0;
`endif
        end else begin
            state    <= state_d;
            pos      <= pos_d;
            wait_cnt <= wait_d;
            winner   <= winner_d;
            led      <= led_d;
`ifdef TOW_TIMEOUT_EN
            to_cnt   <= to_d;
`endif
        end
    end

    always_comb begin
        state_d  = state;
        pos_d    = pos;
        wait_d   = wait_cnt;
        winner_d = winner;
`ifdef TOW_TIMEOUT_EN
        to_d     = '0;
`endif
        case (state)
            IDLE: begin
                if (tick) begin
                    wait_d  = reload;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (pl | pr) begin
                    wait_d = reload;
                end else if (tick) begin
                    wait_d = wait_cnt - 1'b1;
                    if (wait_cnt == CW'(1)) state_d = ARMED;
                end
            end
            ARMED: begin
`ifdef TOW_TIMEOUT_EN
                to_d = to_cnt;
`endif
                if (pl | pr) begin
                    wait_d  = reload;
                    state_d = WAIT;
`ifdef TOW_TIMEOUT_EN
                end else if (tick) begin
                    to_d = to_cnt + 1'b1;
                    if (to_cnt == 6'd63) begin
                        wait_d  = reload;
                        state_d = WAIT;
                    end
`endif
                end
            end
            default: begin
                if (ls[1] & rs[1]) begin
                    state_d  = IDLE;
                    pos_d    = PW'(C);
                    winner_d = 2'b00;
                end
            end
        endcase
        // Scoring at the track end ends the match instead of moving the marker.
        if (left_pt) begin
            if (pos == PW'(LED_W - 1)) begin
                state_d  = WON;
                winner_d = 2'b10;
            end else begin
                pos_d = pos + 1'b1;
            end
        end else if (right_pt) begin
            if (pos == '0) begin
                state_d  = WON;
                winner_d = 2'b01;
            end else begin
                pos_d = pos - 1'b1;
            end
        end
        led_d = state_d == WON ? (winner_d[1] ? HIGH_M : LOW_M) : LED_W'(1) << pos_d;
    end
endmodule
